// File: rtl/motor_pkg.sv
// motor_pkg: shared widths, PWM period, channel states and command record for motor_drive
package motor_pkg;
    localparam int DUTY_W     = 8;
    localparam int PWM_PERIOD = 256;

    typedef enum logic [1:0] {
        ST_COAST = 2'd0,
        ST_DEAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } chan_state_e;

    typedef struct packed {
        logic [DUTY_W-1:0] duty_a;
        logic [DUTY_W-1:0] duty_b;
        logic              dir_a;
        logic              dir_b;
    } cmd_t;

    localparam cmd_t CMD_RESET = '{duty_a: '0, duty_b: '0, dir_a: 1'b1, dir_b: 1'b1};

    // One soft-start step: move the effective duty one count toward the target
    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur, input logic [DUTY_W-1:0] tgt);
        return (cur < tgt) ? cur + 1'b1 : (cur > tgt) ? cur - 1'b1 : cur;
    endfunction
endpackage

// File: rtl/motor_drive_if.sv
// motor_drive_if: two-channel drive command handshake (valid/ready plus duty and direction per channel)
interface motor_drive_if
    import motor_pkg::*;
    ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DUTY_W-1:0] cmd_duty_a;
    logic [DUTY_W-1:0] cmd_duty_b;
    logic              cmd_dir_a;
    logic              cmd_dir_b;

    modport master (
        output cmd_valid, cmd_duty_a, cmd_duty_b, cmd_dir_a, cmd_dir_b,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_duty_a, cmd_duty_b, cmd_dir_a, cmd_dir_b,
        output cmd_ready
    );
endinterface

// File: rtl/motor_pwm_chan.sv
// motor_pwm_chan: one H-bridge channel -- COAST/DEAD/RUN/FAULT FSM, saturating dead-time counter and PWM compare.
// Optional soft start (ramp of effective duty) is built when MOTOR_DRIVE_SOFTSTART_EN is defined.
module motor_pwm_chan
    import motor_pkg::*;
#(
    parameter int DEAD_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              on_current_i,
`ifdef MOTOR_DRIVE_SOFTSTART_EN
    input  logic              wrap_i,
`endif
    input  logic [DUTY_W-1:0] pwm_cnt_i,
    input  logic [DUTY_W-1:0] duty_i,
    input  logic              dir_i,
    output logic              en_o,
    output logic              in_p_o,
    output logic              in_n_o,
    output logic              fault_o
);
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [DW-1:0] DEAD_MAX  = DW'(DEAD_CYCLES);

    chan_state_e       state_q, state_d;
    logic [DW-1:0]     dead_q, dead_d;
    logic              last_dir_q, last_dir_d;
    logic              dir_ok_q, dir_ok_d;
    logic              from_fault_q, from_fault_d;
    logic              en_q, in_p_q, in_n_q;
    logic [DUTY_W-1:0] eff;
    logic              busy, run_d;

    assign busy  = duty_i != '0;
    assign run_d = state_d == ST_RUN;

`ifdef MOTOR_DRIVE_SOFTSTART_EN
    logic [DUTY_W-1:0] eff_q;
    assign eff = eff_q;
    // Ramp effective duty one step per period while running; restart from zero in dead time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) eff_q <= '0;
        else if (state_q == ST_DEAD) eff_q <= '0;
        else if (wrap_i && state_q == ST_RUN) eff_q <= step_toward(eff_q, duty_i);
    end
`else
    assign eff = duty_i;
`endif

    // Next state; an overcurrent trip overrides every other transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_COAST: if (busy) state_d = (dir_ok_q && dir_i == last_dir_q) ? ST_RUN : ST_DEAD;
            ST_DEAD:  if (dead_q == DEAD_LAST) state_d = busy ? ST_RUN : ST_COAST;
            ST_RUN:   state_d = !busy ? ST_COAST : (dir_i != last_dir_q) ? ST_DEAD : ST_RUN;
            ST_FAULT: state_d = ST_DEAD;
            default:  state_d = ST_COAST;
        endcase
        if (!on_current_i) state_d = ST_FAULT;
    end

    // Bookkeeping: dead-time count, last driven direction, fault-recovery flag
    always_comb begin
        dead_d       = (state_q == ST_DEAD && state_d == ST_DEAD) ? ((dead_q == DEAD_MAX) ? dead_q : dead_q + DW'(1)) : '0;
        last_dir_d   = run_d ? dir_i : last_dir_q;
        dir_ok_d     = run_d | dir_ok_q;
        from_fault_d = (state_d == ST_FAULT) || (state_d == ST_DEAD && from_fault_q);
    end

    // State and pins; pins follow the next state so they change on the same edge as the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_COAST;
            dead_q       <= '0;
            last_dir_q   <= 1'b1;
            dir_ok_q     <= 1'b0;
            from_fault_q <= 1'b0;
            en_q         <= 1'b0;
            in_p_q       <= 1'b0;
            in_n_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dead_q       <= dead_d;
            last_dir_q   <= last_dir_d;
            dir_ok_q     <= dir_ok_d;
            from_fault_q <= from_fault_d;
            en_q         <= run_d && (pwm_cnt_i < eff);
            in_p_q       <= run_d && dir_i;
            in_n_q       <= run_d && !dir_i;
        end
    end

    assign en_o    = en_q;
    assign in_p_o  = in_p_q;
    assign in_n_o  = in_n_q;
    assign fault_o = from_fault_q;
endmodule

// File: rtl/motor_drive.sv
// motor_drive: dual H-bridge PWM driver -- shared prescaler and 8-bit PWM counter, pending/active command
// registers swapped at the period boundary, two motor_pwm_chan instances. Soft start: MOTOR_DRIVE_SOFTSTART_EN.
module motor_drive
    import motor_pkg::*;
#(
    parameter int PRESCALE    = 390,
    parameter int DEAD_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ON_CURRENT,
    motor_drive_if.slave cmd,
    output logic         ENA,
    output logic         IN1,
    output logic         IN2,
    output logic         ENB,
    output logic         IN3,
    output logic         IN4,
    output logic         fault
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]     presc_q;
    logic [DUTY_W-1:0] pwm_q;
    logic              ready_q;
    cmd_t              pend_q, act_q, cmd_in;
    logic              tick, wrap, hs, fault_a, fault_b;

    assign tick   = presc_q == PW'(PRESCALE - 1);
    assign wrap   = tick && pwm_q == DUTY_W'(PWM_PERIOD - 1);
    assign hs     = cmd.cmd_valid && ready_q;
    assign cmd_in = {cmd.cmd_duty_a, cmd.cmd_duty_b, cmd.cmd_dir_a, cmd.cmd_dir_b};

    // Prescaler and shared PWM counter; the 255->0 wrap marks the period boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            pwm_q   <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (tick) pwm_q <= pwm_q + DUTY_W'(1);
        end
    end

    // Commands land in pending; active takes pending (or a same-cycle handshake) only at the boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            pend_q  <= CMD_RESET;
            act_q   <= CMD_RESET;
        end else begin
            ready_q <= 1'b1;
            if (hs) pend_q <= cmd_in;
            if (wrap) act_q <= hs ? cmd_in : pend_q;
        end
    end

    assign cmd.cmd_ready = ready_q;

    motor_pwm_chan #(.DEAD_CYCLES(DEAD_CYCLES)) u_chan_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .on_current_i (ON_CURRENT),
`ifdef MOTOR_DRIVE_SOFTSTART_EN
        .wrap_i       (wrap),
`endif
        .pwm_cnt_i    (pwm_q),
        .duty_i       (act_q.duty_a),
        .dir_i        (act_q.dir_a),
        .en_o         (ENA),
        .in_p_o       (IN1),
        .in_n_o       (IN2),
        .fault_o      (fault_a)
    );

    motor_pwm_chan #(.DEAD_CYCLES(DEAD_CYCLES)) u_chan_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .on_current_i (ON_CURRENT),
`ifdef MOTOR_DRIVE_SOFTSTART_EN
        .wrap_i       (wrap),
`endif
        .pwm_cnt_i    (pwm_q),
        .duty_i       (act_q.duty_b),
        .dir_i        (act_q.dir_b),
        .en_o         (ENB),
        .in_p_o       (IN3),
        .in_n_o       (IN4),
        .fault_o      (fault_b)
    );

    assign fault = fault_a | fault_b;
endmodule

// File: tb/tb_motor_drive.sv
// tb_motor_drive: directed checks of motor_drive with PRESCALE=1, DEAD_CYCLES=4
module tb_motor_drive;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ON_CURRENT = 1'b1;
    logic ENA, IN1, IN2, ENB, IN3, IN4, fault;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   overlap = 1'b0;

    motor_drive_if cmd ();

    motor_drive #(.PRESCALE(1), .DEAD_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ON_CURRENT (ON_CURRENT),
        .cmd        (cmd),
        .ENA        (ENA),
        .IN1        (IN1),
        .IN2        (IN2),
        .ENB        (ENB),
        .IN3        (IN3),
        .IN4        (IN4),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Edges since reset release; with PRESCALE=1 the PWM count after edge n is n mod 256
    always @(posedge clk or negedge rst_n) cyc <= rst_n ? cyc + 1 : 0;

    always @(negedge clk) if ((IN1 && IN2) || (IN3 && IN4)) overlap = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] da, input logic ra, input logic [7:0] db, input logic rb, output int h);
        cmd.cmd_duty_a = da;
        cmd.cmd_dir_a  = ra;
        cmd.cmd_duty_b = db;
        cmd.cmd_dir_b  = rb;
        cmd.cmd_valid  = 1'b1;
        @(negedge clk);
        h = cyc;
        cmd.cmd_valid = 1'b0;
    endtask

    function automatic int nw(input int h);
        return ((h + 255) / 256) * 256;
    endfunction

    task automatic count_en(input int from, output int ca, output int cb);
        wait_to(from);
        ca = 0;
        cb = 0;
        repeat (256) begin
            ca += int'(ENA);
            cb += int'(ENB);
            @(negedge clk);
        end
    endtask

    initial begin
        int h, h2, e, f0, ca, cb, lows;
        cmd.cmd_valid  = 1'b0;
        cmd.cmd_duty_a = '0;
        cmd.cmd_duty_b = '0;
        cmd.cmd_dir_a  = 1'b1;
        cmd.cmd_dir_b  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pins", {ENA, IN1, IN2, ENB, IN3, IN4}, 0);
        chk("rst_fault", fault, 0);
        chk("rst_ready", cmd.cmd_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", cmd.cmd_ready, 1);
        chk("idle_pins", {ENA, IN1, IN2, ENB, IN3, IN4}, 0);
`ifdef MOTOR_DRIVE_SOFTSTART_EN
        send(8'd3, 1'b1, 8'd0, 1'b1, h);
        for (int i = 0; i < 2000 && !ENA; i++) @(negedge clk);
        chk("ss_rise", ENA, 1);
        for (int k = 0; k < 4; k++) begin
            ca = 0;
            repeat (256) begin
                ca += int'(ENA);
                @(negedge clk);
            end
            chk($sformatf("ss_period%0d", k), ca, (k < 3) ? k + 1 : 3);
        end
`else
        // Duty 64 forward from idle: dead time, then 64/256 high
        send(8'd64, 1'b1, 8'd0, 1'b1, h);
        e = nw(h);
        wait_to(e + 4);
        chk("a_dead_end", {ENA, IN1, IN2}, 0);
        wait_to(e + 5);
        chk("a_fwd_dir", {IN1, IN2}, 2'b10);
        count_en(e + 6, ca, cb);
        chk("a_duty64", ca, 64);
        chk("b_idle", {ENB, IN3, IN4}, 0);
        // Duty 128 forward, then reverse: exactly four cycles with both A direction pins low
        send(8'd128, 1'b1, 8'd100, 1'b1, h);
        e = nw(h);
        wait_to(e + 300);
        send(8'd128, 1'b0, 8'd100, 1'b1, h2);
        e = nw(h2);
        wait_to(e);
        chk("rev_pre_in1", IN1, 1);
        lows = 0;
        for (int i = 0; i < 20 && !IN2; i++) begin
            @(negedge clk);
            lows += int'(!IN1 && !IN2);
        end
        chk("rev_dead_len", lows, 4);
        chk("rev_at", cyc, e + 5);
        chk("rev_dir", {IN1, IN2}, 2'b01);
        // One-cycle overcurrent trip while running
        f0 = e + 100;
        wait_to(f0 - 1);
        ON_CURRENT = 1'b0;
        @(negedge clk);
        ON_CURRENT = 1'b1;
        chk("trip_pins", {ENA, IN1, IN2, ENB, IN3, IN4}, 0);
        chk("trip_fault", fault, 1);
        wait_to(f0 + 4);
        chk("trip_dead_pins", {ENA, IN1, IN2, ENB, IN3, IN4}, 0);
        chk("trip_dead_fault", fault, 1);
        wait_to(f0 + 5);
        chk("trip_clear", fault, 0);
        chk("trip_resume", {IN1, IN2, IN3, IN4}, 4'b0110);
        count_en(f0 + 6, ca, cb);
        chk("trip_duty_a", ca, 128);
        chk("trip_duty_b", cb, 100);
        // Two handshakes inside one period: only the later one takes effect
        wait_to(cyc - cyc % 256 + 266);
        send(8'd10, 1'b0, 8'd100, 1'b1, h);
        send(8'd200, 1'b0, 8'd100, 1'b1, h2);
        e = nw(h2);
        count_en(e + 1, ca, cb);
        chk("overwrite_a", ca, 200);
        chk("overwrite_b", cb, 100);
        // Back to forward, trip, then reset during the recovery dead time
        send(8'd200, 1'b1, 8'd100, 1'b1, h);
        e = nw(h);
        wait_to(e + 5);
        chk("fwd_again", {IN1, IN2}, 2'b10);
        f0 = e + 100;
        wait_to(f0 - 1);
        ON_CURRENT = 1'b0;
        @(negedge clk);
        ON_CURRENT = 1'b1;
        wait_to(f0 + 2);
        chk("mid_dead_fault", fault, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pins", {ENA, IN1, IN2, ENB, IN3, IN4}, 0);
        chk("async_rst_fault", fault, 0);
        chk("async_rst_ready", cmd.cmd_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'd50, 1'b1, 8'd0, 1'b1, h);
        e = nw(h);
        wait_to(e + 4);
        chk("post_rst_dead", {ENA, IN1, IN2}, 0);
        wait_to(e + 5);
        chk("post_rst_run", {IN1, IN2}, 2'b10);
        count_en(e + 6, ca, cb);
        chk("post_rst_duty", ca, 50);
        // Trip on the boundary edge: fault wins, new duty still becomes active
        send(8'd100, 1'b1, 8'd0, 1'b1, h);
        e = nw(h);
        wait_to(e - 1);
        ON_CURRENT = 1'b0;
        @(negedge clk);
        ON_CURRENT = 1'b1;
        chk("bnd_trip_pins", {ENA, IN1, IN2, ENB, IN3, IN4}, 0);
        chk("bnd_trip_fault", fault, 1);
        wait_to(e + 4);
        chk("bnd_dead", {fault, IN1}, 2'b10);
        wait_to(e + 5);
        chk("bnd_resume", {fault, IN1, IN2}, 3'b010);
        count_en(e + 6, ca, cb);
        chk("bnd_new_duty", ca, 100);
`endif
        chk("no_shoot_through", overlap, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/motor_drive.md
MOTOR_DRIVE -- requirements
Module: motor_drive

Interface
REQ-001 SHALL have parameter PRESCALE, default 390; clk cycles per PWM tick (100 MHz / 390 / 256 ≈ 1 kHz PWM).
REQ-002 SHALL have parameter DEAD_CYCLES, default 100000; coast time in clk cycles before any direction change or fault recovery.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ON_CURRENT  input  1  current-protection permit; 1 = drive allowed, 0 = overcurrent trip.
REQ-006 SHALL have port cmd_valid  input  1  command strobe.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 SHALL have port cmd_duty_a / cmd_duty_b  input  8 each  target duty, 0..255 of 256.
REQ-009 SHALL have port cmd_dir_a / cmd_dir_b  input  1 each  1 = forward, 0 = reverse.
REQ-010 SHALL have ports ENA, IN1, IN2 / ENB, IN3, IN4  output  1 each  H-bridge enable and direction pins, channels A and B.
REQ-011 SHALL have port fault  output  1  high while the drive is tripped or recovering.

Function
REQ-012 SHALL drive a shared 8-bit PWM counter that increments once per PRESCALE clk cycles and wraps 255->0; the wrap is the period boundary.
REQ-013 SHALL hold cmd_ready high whenever out of reset; a handshake copies all four cmd fields into a pending register; a later handshake before the boundary overwrites it.
REQ-014 SHALL transfer pending to active on the period boundary only; latency from handshake to pin change SHALL be no more than one PWM period plus one clk.
REQ-015 SHALL give each channel states COAST, DEAD, RUN and FAULT.
REQ-016 COAST: ENx=0, INs=0; SHALL go to RUN when active duty != 0 and the direction is unchanged since the last RUN, otherwise to DEAD.
REQ-017 DEAD: ENx=0, INs=0 for exactly DEAD_CYCLES clk; SHALL then go to RUN if duty != 0, else COAST.
REQ-018 RUN: ENx = (pwm_cnt < duty), registered; IN1/IN3 = dir, IN2/IN4 = ~dir. Duty 0 SHALL go to COAST. A direction change SHALL go to DEAD.
REQ-019 IN1 and IN2 (and IN3 and IN4) SHALL never both be high in any cycle.
REQ-020 ON_CURRENT=0 in any state SHALL force FAULT on both channels on the next clk edge, with all six pins low.
REQ-021 FAULT SHALL exit to DEAD on the first cycle ON_CURRENT=1, so DEAD_CYCLES of coast are enforced before re-drive.
REQ-022 fault SHALL be high in FAULT, and in the DEAD state entered from FAULT.
REQ-023 ON_CURRENT low coinciding with a period boundary SHALL give FAULT priority; the pending command SHALL still transfer to active.
REQ-024 The DEAD counter SHALL be ceil(log2(DEAD_CYCLES+1)) bits and saturate without wrapping.

Reset
REQ-025 With rst_n low, all six pins and fault SHALL be 0, cmd_ready 0, states COAST, duties 0, dirs 1, and all counters 0.
REQ-026 Reset mid-DEAD or mid-FAULT SHALL abort the state; after release the first drive SHALL go through DEAD, because the last direction is unknown.

Configuration
REQ-027 With MOTOR_DRIVE_SOFTSTART_EN defined, effective duty in RUN SHALL step by ±1 per period boundary toward the active target, and SHALL restart from 0 after DEAD.
REQ-028 Without MOTOR_DRIVE_SOFTSTART_EN, effective duty SHALL equal the active target at the boundary.

Structure
REQ-029 Package motor_pkg SHALL hold the duty width constant (8), the PWM period (256) and the channel state enum.
REQ-030 Per-channel FSM, dead counter and ENx compare SHALL live in sub-module motor_pwm_chan, instantiated twice; the shared prescaler, PWM counter and command register stay in motor_drive.

Verification
REQ-031 PRESCALE=1, DEAD_CYCLES=4; cmd duty_a=64, dir_a=1 -> after DEAD (4 clk), ENA high 64 of every 256 clk, IN1=1, IN2=0.
REQ-032 In RUN at duty 128 forward, command reverse -> at the next boundary all A pins low for exactly 4 clk, then IN2=1, IN1=0, with no cycle of IN1&IN2.
REQ-033 ON_CURRENT pulsed low 1 clk while running -> all six pins 0 and fault=1 on the next edge; DEAD for 4 clk after ON_CURRENT=1; then the prior duty resumes.
REQ-034 Two handshakes (duty 10, then 200) within one period -> only duty 200 appears at the next boundary.
REQ-035 rst_n asserted mid-DEAD -> all outputs 0 asynchronously; after release, duty 50 forward passes through a full 4-clk DEAD.
REQ-036 MOTOR_DRIVE_SOFTSTART_EN defined, duty 3 -> ENA high-count per period goes 1, 2, 3, 3.
